// File: rtl/nurn_cfg_pkg.sv
// nurn_cfg_pkg: target codes, header layout, loader FSM states and target address width helper
package nurn_cfg_pkg;
    localparam logic [2:0] TGT_CFG_A   = 3'd0;
    localparam logic [2:0] TGT_CFG_B   = 3'd1;
    localparam logic [2:0] TGT_CFG_C   = 3'd2;
    localparam logic [2:0] TGT_STAT    = 3'd3;
    localparam logic [2:0] TGT_STAT_WT = 3'd4;

    localparam int HDR_TGT_LSB  = 29;
    localparam int HDR_TGT_W    = 3;
    localparam int HDR_LEN_LSB  = 16;
    localparam int HDR_LEN_W    = 13;
    localparam int HDR_BASE_LSB = 0;
    localparam int HDR_BASE_W   = 16;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        DATA = 4'b0010,
        DROP = 4'b0100,
        DONE = 4'b1000
    } state_e;

    // Address width of a target memory; illegal codes get 0 (their address is never used).
    function automatic int tgt_tw(input logic [2:0] tgt, input int nb, input int ab);
        return (tgt == TGT_CFG_A || tgt == TGT_CFG_B)   ? nb :
               (tgt == TGT_CFG_C || tgt == TGT_STAT_WT) ? nb + ab :
               (tgt == TGT_STAT)                        ? nb + 2 : 0;
    endfunction
endpackage

// File: rtl/nurn_cfg_loader.sv
// nurn_cfg_loader: NoC config-packet writer into neuron memories with neuron-start interlock
module nurn_cfg_loader
    import nurn_cfg_pkg::*;
#(
    parameter int FLIT_W             = 32,
    parameter int DATA_W             = 16,
    parameter int NURN_CNT_BIT_WIDTH = 2,
    parameter int AXON_CNT_BIT_WIDTH = 2,
    parameter int ADDR_W             = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic              flit_ready_o,
    input  logic              nurn_busy_i,
    input  logic              start_req_i,
    output logic              start_o,
    output logic              wrEn_o,
    output logic [4:0]        wrSel_o,
    output logic [ADDR_W-1:0] wrAddr_o,
    output logic [DATA_W-1:0] wrData_o,
    output logic              busy_o,
    output logic              load_done_o,
    output logic              err_o
);
    state_e               state_q, state_d;
    logic [2:0]           tgt_q, tgt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [HDR_LEN_W-1:0] cnt_q, cnt_d;
    logic                 pend_q, pend_d, start_q, start_d, err_q, err_d;
    logic                 wr_en_q, wr_en_d;
    logic [4:0]           wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;

    logic [2:0]           hdr_tgt;
    logic [HDR_LEN_W-1:0] hdr_len;
    logic [ADDR_W-1:0]    hdr_mask, cur_mask;
    logic                 hdr_ok, acc, hdr_acc;

    assign hdr_tgt  = flit_i[HDR_TGT_LSB +: HDR_TGT_W];
    assign hdr_len  = flit_i[HDR_LEN_LSB +: HDR_LEN_W];
    assign hdr_ok   = hdr_tgt <= TGT_STAT_WT;
    assign hdr_mask = ADDR_W'((32'd1 << tgt_tw(hdr_tgt, NURN_CNT_BIT_WIDTH, AXON_CNT_BIT_WIDTH)) - 32'd1);
    assign cur_mask = ADDR_W'((32'd1 << tgt_tw(tgt_q, NURN_CNT_BIT_WIDTH, AXON_CNT_BIT_WIDTH)) - 32'd1);

    // A pending start owns the IDLE cycle it is issued in, so no header is taken then.
    assign flit_ready_o = !rst_i && (state_q == IDLE ? (!nurn_busy_i && !pend_q) : (state_q != DONE));
    assign acc          = flit_valid_i && flit_ready_o;
    assign hdr_acc      = acc && state_q == IDLE;

    assign start_o     = start_q;
    assign wrEn_o      = wr_en_q;
    assign wrSel_o     = wr_sel_q;
    assign wrAddr_o    = wr_addr_q;
    assign wrData_o    = wr_data_q;
    assign err_o       = err_q;
    assign busy_o      = state_q != IDLE;
    assign load_done_o = state_q == DONE;

    // Next state: header decode, data burst / drop counting, and start interlock.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q || start_req_i;
        start_d   = 1'b0;
        err_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_sel_d  = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        case (state_q)
            IDLE: begin
                if (hdr_acc) begin
                    tgt_d   = hdr_tgt;
                    addr_d  = ADDR_W'(flit_i[HDR_BASE_LSB +: HDR_BASE_W]) & hdr_mask;
                    cnt_d   = hdr_len;
                    err_d   = !hdr_ok;
                    state_d = hdr_len == '0 ? (hdr_ok ? DONE : IDLE) : (hdr_ok ? DATA : DROP);
                end
                start_d = pend_q || (start_req_i && !hdr_acc);
                pend_d  = start_req_i && hdr_acc;
            end
            DATA: begin
                if (acc) begin
                    wr_en_d   = 1'b1;
                    wr_sel_d  = 5'd1 << tgt_q;
                    wr_addr_d = addr_q;
                    wr_data_d = flit_i[DATA_W-1:0];
                    addr_d    = (addr_q + 1'b1) & cur_mask;
                    cnt_d     = cnt_q - 1'b1;
                    state_d   = cnt_q == HDR_LEN_W'(1) ? DONE : DATA;
                end
            end
            DROP: begin
                if (acc) begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == HDR_LEN_W'(1) ? IDLE : DROP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered write bus; reset aborts any packet and drops a pending start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            start_q   <= start_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_nurn_cfg_loader.sv
// tb_nurn_cfg_loader: directed checks of packet loading, wrap, drop, busy hold-off, start interlock and reset
module tb_nurn_cfg_loader;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] flit_i = '0;
    logic        flit_valid_i = 1'b0;
    logic        flit_ready_o;
    logic        nurn_busy_i = 1'b0;
    logic        start_req_i = 1'b0;
    logic        start_o, wrEn_o, busy_o, load_done_o, err_o;
    logic [4:0]  wrSel_o;
    logic [3:0]  wrAddr_o;
    logic [15:0] wrData_o;
    int          checks = 0;
    int          failures = 0;

    nurn_cfg_loader dut (
        .clk_i(clk_i), .rst_i(rst_i), .flit_i(flit_i), .flit_valid_i(flit_valid_i),
        .flit_ready_o(flit_ready_o), .nurn_busy_i(nurn_busy_i), .start_req_i(start_req_i),
        .start_o(start_o), .wrEn_o(wrEn_o), .wrSel_o(wrSel_o), .wrAddr_o(wrAddr_o),
        .wrData_o(wrData_o), .busy_o(busy_o), .load_done_o(load_done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] hdr(input logic [2:0] t, input logic [12:0] l, input logic [15:0] b);
        return {t, l, b};
    endfunction

    // Present one data flit, let it be accepted and check the write it produces.
    task automatic wr_word(input logic [15:0] d, input logic [4:0] sel, input logic [3:0] addr, input logic done);
        flit_i = {16'hA5A5, d};
        flit_valid_i = 1'b1;
        tick;
        chk("wr_en", wrEn_o, 1'b1);
        chk("wr_sel", wrSel_o, sel);
        chk("wr_addr", wrAddr_o, addr);
        chk("wr_data", wrData_o, d);
        chk("wr_done", load_done_o, done);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_ready", flit_ready_o, 1'b0);
        chk("rst_outs", {start_o, wrEn_o, wrSel_o, wrAddr_o, wrData_o, busy_o, load_done_o, err_o}, '0);
        rst_i = 1'b0;
        #1;
        chk("idle_ready", flit_ready_o, 1'b1);

        // STAT target, 4-bit address: 6,7,8,9
        flit_i = hdr(3'd3, 13'd4, 16'h0006);
        flit_valid_i = 1'b1;
        tick;
        chk("t1_busy", busy_o, 1'b1);
        chk("t1_no_wr", wrEn_o, 1'b0);
        wr_word(16'h1000, 5'b01000, 4'd6, 1'b0);
        wr_word(16'h1001, 5'b01000, 4'd7, 1'b0);
        wr_word(16'h1002, 5'b01000, 4'd8, 1'b0);
        wr_word(16'h1003, 5'b01000, 4'd9, 1'b1);
        flit_valid_i = 1'b0;
        tick;
        chk("t1_done_off", load_done_o, 1'b0);
        chk("t1_idle", busy_o, 1'b0);
        chk("t1_wr_off", wrEn_o, 1'b0);

        // CFG_A, 2-bit address wraps 2,3,0,1,2,3 with a valid gap mid-burst
        flit_i = hdr(3'd0, 13'd6, 16'h0002);
        flit_valid_i = 1'b1;
        tick;
        wr_word(16'h2000, 5'b00001, 4'd2, 1'b0);
        wr_word(16'h2111, 5'b00001, 4'd3, 1'b0);
        wr_word(16'h2222, 5'b00001, 4'd0, 1'b0);
        flit_valid_i = 1'b0;
        tick;
        chk("t2_gap_wr", wrEn_o, 1'b0);
        chk("t2_gap_busy", busy_o, 1'b1);
        wr_word(16'h2333, 5'b00001, 4'd1, 1'b0);
        wr_word(16'h2444, 5'b00001, 4'd2, 1'b0);
        wr_word(16'h2555, 5'b00001, 4'd3, 1'b1);
        flit_valid_i = 1'b0;
        tick;

        // illegal target: error pulse, three flits swallowed, no writes
        flit_i = hdr(3'd6, 13'd3, 16'h0001);
        flit_valid_i = 1'b1;
        tick;
        chk("t3_err", err_o, 1'b1);
        chk("t3_busy", busy_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            flit_i = 32'h0000_BEEF + i;
            tick;
            chk("t3_no_wr", wrEn_o, 1'b0);
            chk("t3_err_off", err_o, 1'b0);
            chk("t3_drop_busy", busy_o, i < 2);
        end
        flit_valid_i = 1'b0;
        #1;
        chk("t3_ready", flit_ready_o, 1'b1);

        // neuron busy holds off the header; once in DATA, busy is ignored
        nurn_busy_i = 1'b1;
        flit_i = hdr(3'd1, 13'd1, 16'h0001);
        flit_valid_i = 1'b1;
        #1;
        chk("t4_hold_ready", flit_ready_o, 1'b0);
        tick;
        tick;
        chk("t4_not_taken", busy_o, 1'b0);
        nurn_busy_i = 1'b0;
        #1;
        chk("t4_ready", flit_ready_o, 1'b1);
        tick;
        chk("t4_taken", busy_o, 1'b1);
        nurn_busy_i = 1'b1;
        #1;
        chk("t4_data_ready", flit_ready_o, 1'b1);
        wr_word(16'h4444, 5'b00010, 4'd1, 1'b1);
        nurn_busy_i = 1'b0;
        flit_valid_i = 1'b0;
        tick;

        // direct start in IDLE
        start_req_i = 1'b1;
        tick;
        start_req_i = 1'b0;
        chk("t5_start_direct", start_o, 1'b1);
        tick;
        chk("t5_start_off", start_o, 1'b0);

        // two requests during a packet collapse to one start after IDLE re-entry
        flit_i = hdr(3'd2, 13'd2, 16'h0005);
        flit_valid_i = 1'b1;
        tick;
        start_req_i = 1'b1;
        wr_word(16'h5000, 5'b00100, 4'd5, 1'b0);
        chk("t5_no_start_a", start_o, 1'b0);
        start_req_i = 1'b0;
        wr_word(16'h5001, 5'b00100, 4'd6, 1'b1);
        start_req_i = 1'b1;
        flit_i = hdr(3'd4, 13'd1, 16'h0003);
        tick;
        start_req_i = 1'b0;
        chk("t5_no_start_b", start_o, 1'b0);
        chk("t5_idle", busy_o, 1'b0);
        chk("t5_holdoff", flit_ready_o, 1'b0);
        tick;
        chk("t5_start", start_o, 1'b1);
        chk("t5_hdr_held", busy_o, 1'b0);
        chk("t5_ready_back", flit_ready_o, 1'b1);
        tick;
        chk("t5_one_start", start_o, 1'b0);
        chk("t5_hdr_taken", busy_o, 1'b1);
        wr_word(16'h5555, 5'b10000, 4'd3, 1'b1);
        flit_valid_i = 1'b0;
        tick;
        chk("t5_no_extra", start_o, 1'b0);

        // reset mid-packet after the 2nd of 5 flits, also clearing a pended start
        flit_i = hdr(3'd3, 13'd5, 16'h000E);
        flit_valid_i = 1'b1;
        start_req_i = 1'b1;
        tick;
        start_req_i = 1'b0;
        chk("t6_start_pended", start_o, 1'b0);
        wr_word(16'h6000, 5'b01000, 4'd14, 1'b0);
        wr_word(16'h6001, 5'b01000, 4'd15, 1'b0);
        rst_i = 1'b1;
        flit_i = 32'h0000_6002;
        #1;
        chk("t6_rst_ready", flit_ready_o, 1'b0);
        tick;
        chk("t6_rst_outs", {start_o, wrEn_o, wrSel_o, wrAddr_o, wrData_o, busy_o, load_done_o, err_o}, '0);
        rst_i = 1'b0;
        flit_valid_i = 1'b0;
        tick;
        chk("t6_no_start_a", start_o, 1'b0);
        chk("t6_idle", busy_o, 1'b0);
        tick;
        chk("t6_no_start_b", start_o, 1'b0);
        chk("t6_no_wr", wrEn_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
